// File: rtl/ctrl_stream_gen.sv
// MASH control-word generator: FIFO-buffered offset-binary samples are held DSR clocks each and then drive an M-stage carry cascade.
// Latency: a sample loads at the next ph==DSR-1 edge, and out is registered one clock after each stage sum; backpressure: o_in_ready is low while the FIFO is full.
module csg_fifo #(
    parameter int W     = 12,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_push,
    input  logic [W-1:0] i_dat,
    input  logic         i_pop,
    output logic [W-1:0] o_dat,
    output logic         o_full,
    output logic         o_empty
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [AW:0]   r_count;
    logic          w_push;
    logic          w_pop;

    assign o_full  = (r_count == (AW+1)'(DEPTH));
    assign o_empty = (r_count == '0);
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;
    assign o_dat   = r_mem[r_rptr];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + AW'(1);
            if (w_pop)  r_rptr <= r_rptr + AW'(1);
            r_count <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wptr] <= i_dat;
    end
endmodule

module ctrl_stream_gen #(
    parameter int M          = 3,
    parameter int DSR        = 12,
    parameter int IN_WIDTH   = 12,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [IN_WIDTH-1:0] i_in,
    input  logic                i_in_valid,
    output logic                o_in_ready,
    output logic [M-1:0]        o_out,
    output logic                o_out_valid,
    output logic                o_underrun
);
    localparam int W    = IN_WIDTH;
    localparam int PH_W = (DSR > 1) ? $clog2(DSR) : 1;
    localparam logic [PH_W-1:0] PH_LAST = PH_W'(DSR - 1);

    logic [PH_W-1:0] r_ph;
    logic [W-1:0]    r_hold;
    logic            r_loaded;
    logic            r_out_valid;
    logic            r_underrun;
    logic [W-1:0]    r_acc [M];
    logic [M-1:0]    r_out;
    logic [W:0]      w_sum [M];
    logic            w_boundary;
    logic            w_fifo_full;
    logic            w_fifo_empty;
    logic [W-1:0]    w_fifo_dat;

    assign w_boundary  = (r_ph == PH_LAST);
    assign o_in_ready  = !w_fifo_full;
    assign o_out       = r_out;
    assign o_out_valid = r_out_valid;
    assign o_underrun  = r_underrun;

    csg_fifo #(.W(W), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (i_in_valid),
        .i_dat   (i_in),
        .i_pop   (w_boundary),
        .o_dat   (w_fifo_dat),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ph        <= '0;
            r_hold      <= '0;
            r_loaded    <= 1'b0;
            r_out_valid <= 1'b0;
            r_underrun  <= 1'b0;
        end else begin
            r_ph        <= w_boundary ? '0 : r_ph + PH_W'(1);
            r_out_valid <= r_loaded;
            if (w_boundary) begin
                if (!w_fifo_empty) begin
                    r_hold   <= w_fifo_dat;
                    r_loaded <= 1'b1;
                end else if (r_loaded) begin
                    // An empty FIFO before the first load is start-up, not starvation.
                    r_underrun <= 1'b1;
                end
            end
        end
    end

    // Each stage integrates the previous stage's registered accumulator, so the cascade is pipelined.
    for (genvar k = 0; k < M; k++) begin : g_stage
        logic [W-1:0] w_stage_in;
        if (k == 0) begin : g_first
            assign w_stage_in = r_hold;
        end else begin : g_rest
            assign w_stage_in = r_acc[k-1];
        end
        assign w_sum[k] = {1'b0, r_acc[k]} + {1'b0, w_stage_in};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < M; k++) r_acc[k] <= '0;
            r_out <= '0;
        end else if (r_loaded) begin
            for (int k = 0; k < M; k++) begin
                r_acc[k] <= w_sum[k][W-1:0];
                r_out[k] <= w_sum[k][W];
            end
        end
    end
endmodule

// File: tb/tb_ctrl_stream_gen.sv
// Bench for ctrl_stream_gen: a queue-based reference model feeds a scoreboard checked every clock, plus directed density/back-pressure/reset checks.
module tb_ctrl_stream_gen;
    localparam int M = 3, DSR = 12, W = 12, DEPTH = 4, MOD = 4096;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [W-1:0] i_in = '0;
    logic         i_in_valid = 1'b0;
    logic         o_in_ready;
    logic [M-1:0] o_out;
    logic         o_out_valid;
    logic         o_underrun;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    ctrl_stream_gen #(.M(M), .DSR(DSR), .IN_WIDTH(W), .FIFO_DEPTH(DEPTH)) dut (
        .clk         (clk),
        .rst         (rst),
        .i_in        (i_in),
        .i_in_valid  (i_in_valid),
        .o_in_ready  (o_in_ready),
        .o_out       (o_out),
        .o_out_valid (o_out_valid),
        .o_underrun  (o_underrun)
    );

    typedef struct packed {
        logic [M-1:0] out;
        logic         ov;
        logic         ur;
        logic         rdy;
        logic [W-1:0] hold;
    } exp_t;

    exp_t         sb_q[$];
    int           m_q[$];
    int           m_ph, m_hold;
    int           m_acc [M];
    bit           m_loaded, m_ov, m_ur;
    logic [M-1:0] m_out;

    function automatic exp_t m_snap();
        exp_t e;
        e.out  = m_out;
        e.ov   = m_ov;
        e.ur   = m_ur;
        e.rdy  = (m_q.size() < DEPTH);
        e.hold = W'(m_hold);
        return e;
    endfunction

    // Reference model: sample queue, modular accumulators, phase as a plain counter.
    always @(posedge clk or posedge rst) begin
        bit push;
        int prev [M];
        int sum, stage_in;
        if (rst) begin
            m_q.delete();
            m_ph = 0; m_hold = 0; m_loaded = 0; m_ov = 0; m_ur = 0; m_out = '0;
            for (int k = 0; k < M; k++) m_acc[k] = 0;
            sb_q.delete();
            sb_q.push_back(m_snap());
        end else begin
            push = i_in_valid && (m_q.size() < DEPTH);
            prev = m_acc;
            if (m_loaded) begin
                for (int k = 0; k < M; k++) begin
                    if (k == 0) stage_in = m_hold;
                    else        stage_in = prev[k-1];
                    sum = prev[k] + stage_in;
                    m_acc[k] = sum % MOD;
                    m_out[k] = (sum >= MOD);
                end
            end
            m_ov = m_loaded;
            if (m_ph == DSR - 1) begin
                if (m_q.size() > 0) begin
                    m_hold = m_q.pop_front();
                    m_loaded = 1;
                end else if (m_loaded) begin
                    m_ur = 1;
                end
            end
            if (push) m_q.push_back(int'(i_in));
            m_ph = (m_ph + 1) % DSR;
            sb_q.push_back(m_snap());
        end
    end

    always @(negedge clk) begin
        exp_t e, g;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            g.out  = o_out;
            g.ov   = o_out_valid;
            g.ur   = o_underrun;
            g.rdy  = o_in_ready;
            g.hold = dut.r_hold;
            checks++;
            if (g !== e) begin
                failures++;
                $display("FAIL sb t=%0t got out=%b ov=%b ur=%b rdy=%b hold=%0d exp out=%b ov=%b ur=%b rdy=%b hold=%0d",
                         $time, g.out, g.ov, g.ur, g.rdy, g.hold, e.out, e.ov, e.ur, e.rdy, e.hold);
            end
        end
    end

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", name, got, exp);
        end
    endtask

    int st_ones, st_nz, st_same, st_ovlow;

    // mode: 0 idle, 1 constant val, 2 random dense, 3 random sparse
    task automatic run(input int n, input int mode, input int val);
        logic prev0;
        prev0 = o_out[0];
        st_ones = 0; st_nz = 0; st_same = 0; st_ovlow = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (o_out[0]) st_ones++;
            if (o_out != '0) st_nz++;
            if (i > 0 && o_out[0] == prev0) st_same++;
            if (!o_out_valid) st_ovlow++;
            prev0 = o_out[0];
            case (mode)
                1:       begin i_in_valid = 1'b1; i_in = W'(val); end
                2:       begin i_in_valid = ($urandom_range(0, 7) != 0); i_in = W'($urandom); end
                3:       begin i_in_valid = ($urandom_range(0, 15) == 0); i_in = W'($urandom); end
                default: i_in_valid = 1'b0;
            endcase
        end
    endtask

    task automatic do_reset(input int n);
        @(negedge clk);
        #2 rst = 1'b1;
        i_in_valid = 1'b0;
        repeat (n) @(negedge clk);
        rst = 1'b0;
    endtask

    int vals [5] = '{11, 22, 33, 44, 55};
    int waits [5];
    int wcnt;
    bit rb, acc;

    initial begin
        // Reset and idle
        repeat (3) @(negedge clk);
        rst = 1'b0;
        run(50, 0, 0);
        chk("idle_out_nonzero_cycles", st_nz, 0);
        chk("idle_out_valid_low_cycles", st_ovlow, 50);
        chk("idle_underrun", o_underrun, 0);
        chk("idle_in_ready", o_in_ready, 1);

        // Back-pressure: five pushes from reset release
        do_reset(3);
        for (int i = 0; i < 5; i++) begin
            i_in = W'(vals[i]);
            i_in_valid = 1'b1;
            waits[i] = 0;
            acc = 0;
            while (!acc && waits[i] < 50) begin
                rb = o_in_ready;
                @(negedge clk);
                waits[i]++;
                acc = rb;
            end
            if (i == 3) chk("in_ready_low_after_4th_push", o_in_ready, 0);
        end
        i_in_valid = 1'b0;
        for (int i = 0; i < 4; i++) chk("push_wait_first4", waits[i], 1);
        // Full after the 4th push; the first pop is at the 12th edge, so the 5th lands on edge 13.
        chk("push_wait_5th", waits[4], 9);
        run(60, 0, 0);
        chk("bp_last_hold", dut.r_hold, 55);
        chk("bp_underrun_after_drain", o_underrun, 1);

        // Underrun: one sample then starvation
        do_reset(2);
        i_in = W'(1000);
        i_in_valid = 1'b1;
        @(negedge clk);
        i_in_valid = 1'b0;
        run(20, 0, 0);
        chk("ur_before_2nd_boundary", o_underrun, 0);
        chk("ur_out_valid_on", o_out_valid, 1);
        run(4, 0, 0);
        chk("ur_after_2nd_boundary", o_underrun, 1);
        run(4096, 0, 0);
        chk("ur_density_1000", st_ones, 1000);
        chk("ur_out_valid_never_drops", st_ovlow, 0);
        chk("ur_hold_kept", dut.r_hold, 1000);
        chk("ur_sticky", o_underrun, 1);

        // Constant streams
        do_reset(2);
        run(4296, 1, 0);
        chk("zero_stream_all_bits_zero", st_nz, 0);
        run(200, 1, 2048);
        run(4096, 1, 2048);
        chk("mid_density", st_ones, 2048);
        chk("mid_alternates", st_same, 0);
        run(200, 1, 4095);
        run(4096, 1, 4095);
        chk("max_density", st_ones, 4095);
        run(200, 1, 1);
        run(4096, 1, 1);
        chk("min_density", st_ones, 1);
        run(200, 1, 1000);

        // Mid-operation reset at ph=5 with three FIFO entries
        i_in_valid = 1'b0;
        wcnt = 0;
        while (!(m_q.size() == 3 && m_ph == 5) && wcnt < 40) begin
            @(negedge clk);
            wcnt++;
        end
        chk("midrst_reached_state", (wcnt < 40) ? 1 : 0, 1);
        chk("midrst_ov_before", o_out_valid, 1);
        #2 rst = 1'b1;
        #1;
        chk("midrst_out", o_out, 0);
        chk("midrst_ov", o_out_valid, 0);
        chk("midrst_ur", o_underrun, 0);
        chk("midrst_ready", o_in_ready, 1);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("midrst_ph_restart", dut.r_ph, 0);
        chk("midrst_ready_after", o_in_ready, 1);

        // Random traffic against the model
        run(1500, 2, 0);
        run(1500, 3, 0);
        run(200, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
